// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_if
// Description : Write-back and operand-read bundle for wb_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_regfile_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              Wr_RegWE;
    logic [ADDR_W-1:0] Wr_Rd;
    logic [DATA_W-1:0] Wr_data;
    logic [ADDR_W-1:0] Ra;
    logic [ADDR_W-1:0] Rb;
    logic [DATA_W-1:0] Da;
    logic [DATA_W-1:0] Db;

    // Pipeline side: drives write-back and read indices, consumes operands.
    modport master (
        output Wr_RegWE, Wr_Rd, Wr_data, Ra, Rb,
        input  Da, Db
    );

    // Register file side.
    modport slave (
        input  Wr_RegWE, Wr_Rd, Wr_data, Ra, Rb,
        output Da, Db
    );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : 2^ADDR_W x DATA_W register file, hard-wired zero register,
//               two combinational read ports with same-cycle write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  wire               clk,
    input  wire               reset,
    wb_regfile_if.slave       bus
);
    localparam int                c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero_idx = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_mem [c_depth];
    logic              w_wr_en;

    // Gating on Wr_RegWE first keeps an undefined index from reaching the array.
    assign w_wr_en = bus.Wr_RegWE && (bus.Wr_Rd != c_zero_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem <= '{default: '0};
        end else if (w_wr_en) begin
            r_mem[bus.Wr_Rd] <= bus.Wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] arr_val
    );
        if (reset)
            return '0;
        else if (idx == c_zero_idx)
            return '0;
        else if (bus.Wr_RegWE && (bus.Wr_Rd == idx))
            return bus.Wr_data;
        else
            return arr_val;
    endfunction

    always_comb begin
        bus.Da = read_port(bus.Ra, r_mem[bus.Ra]);
        bus.Db = read_port(bus.Rb, r_mem[bus.Rb]);
    end
endmodule
`default_nettype wire
